// File: rtl/bitmap_index_encoder.sv
// Serialises an 8-bit multi-hot bitmap into one binary index per output beat, lowest first.
// First beat 1 cycle after acceptance; a stalled beat holds all outputs and state until out_ready.
module bitmap_index_encoder #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_vec,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          out_zero
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t         state;
   logic [N-1:0]   pend;
   logic           zf;
   logic [IW-1:0]  lo_idx;
   logic           single_bit;

   // Descending scan so the lowest set bit wins; pend == 0 leaves index 0.
   always_comb begin
      lo_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pend[i]) lo_idx = IW'(i);
      end
   end

   assign single_bit = (pend != '0) && ((pend & (pend - N'(1))) == '0);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == EMIT);
   assign out_idx   = lo_idx;
   assign out_last  = out_valid && (zf || single_bit);
   assign out_zero  = zf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= '0;
         zf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  pend  <= in_vec;
                  zf    <= (in_vec == '0);
                  state <= EMIT;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  // The zero marker beat owns no pend bit; it retires the flag instead.
                  if (zf) zf <= 1'b0;
                  else    pend[lo_idx] <= 1'b0;
                  if (out_last) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/bitmap_index_encoder.md
# bitmap_index_encoder

Sequential bitmap-to-index encoder: accepts an 8-bit multi-hot vector and emits the 3-bit binary index of every set bit, lowest index first, one index per output handshake. It is the inverse of the team's 3-to-8 one-hot decoder. It sits between a request/flag bitmap producer and consumers that take one binary index at a time, such as a register-file write port or a decoder-driven select.

## Interface
Parameters:
- N, 8, input vector width. Only 8 is supported.
- IW, 3, index width. Must equal log2(N).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  N  multi-hot bitmap.
- out_valid  output  1  out_idx / out_last / out_zero are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  IW  binary index of the lowest pending set bit.
- out_last  output  1  current beat is the final beat for this vector.
- out_zero  output  1  the accepted vector was all-zero (marker beat).

## Operation
- State machine has two states, IDLE and EMIT. A pending register pend[N-1:0] and a zero flag zf are held in registers.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - On in_valid && in_ready: pend <= in_vec, zf <= (in_vec == 0), go to EMIT.
- EMIT:
  - in_ready = 0 and out_valid = 1.
  - in_valid is ignored; the vector presented is not captured.
- Outputs in EMIT are combinational functions of pend and zf only. There is no combinational path from any input to any output.
  - out_idx = position of the lowest set bit of pend. When zf = 1, out_idx = 0.
  - out_last = 1 when zf = 1, or when pend has exactly one bit set.
  - out_zero = zf.
- On out_valid && out_ready in EMIT:
  - Clear the bit of pend at out_idx. If zf = 1, clear zf instead.
  - If out_last = 1, return to IDLE; otherwise stay in EMIT.
- Ordering is strictly ascending index; the same bit is never emitted twice.
- An all-zero vector produces exactly one beat: out_idx = 0, out_zero = 1, out_last = 1.
- A vector with k set bits (1..8) produces exactly k beats. out_zero = 0 on every beat, and out_last = 1 only on the k-th beat.
- Backpressure: while out_valid = 1 and out_ready = 0, out_idx, out_last and out_zero hold stable and no state changes.
- out_ready while out_valid = 0 has no effect.

## Timing
- Reset (rst_n = 0) takes effect immediately, with no clock required:
  - state = IDLE, pend = 0, zf = 0.
  - in_ready = 1, out_valid = 0, out_idx = 0, out_last = 0, out_zero = 0.
- Reset asserted mid-vector discards all pending indices. No partial beat is emitted after rst_n deasserts.
- Input acceptance in cycle T gives out_valid = 1 in cycle T+1, so first-beat latency is 1 cycle.
- With out_ready held at 1, beats issue on consecutive cycles T+1 .. T+k, and in_ready = 1 again in cycle T+k+1.
- Input throughput is one vector per (k+1) cycles; in_ready is never high in the same cycle as a beat.
- The last-beat handshake and the next input acceptance cannot coincide. Acceptance occurs at the earliest in the cycle after the last beat.
- All state changes occur on the rising edge of clk, except reset.

## Test plan
- Reset values: hold rst_n = 0 for 3 cycles with random inputs -> in_ready = 1, out_valid = 0, out_idx = 0, out_last = 0, out_zero = 0 throughout.
- Basic encode: in_vec = 8'b1010_0100 accepted at T, out_ready = 1 -> out_idx = 2, 5, 7 at T+1, T+2, T+3. out_last = 0, 0, 1; out_zero = 0 on all beats; in_ready = 1 at T+4.
- All-zero and all-ones vectors:
  - in_vec = 8'h00 -> single beat with out_idx = 0, out_zero = 1, out_last = 1.
  - in_vec = 8'hFF -> 8 beats with out_idx = 0..7, out_last = 1 only on idx 7.
- Backpressure and busy input: in_vec = 8'h81, out_ready = 0 for 4 cycles, then 1, with in_valid held at 1 carrying 8'h3C throughout:
  - out_idx holds at 0 with out_last = 0 during the stall.
  - Beats then emit 0 and 7.
  - 8'h3C is accepted only in the cycle after the idx-7 beat.
- Reset mid-operation: in_vec = 8'hF0, assert rst_n = 0 asynchronously after the idx-4 beat -> out_valid drops immediately. After release, no beats for 5, 6 or 7 appear; the next vector 8'h02 emits only idx 1.
- Random regression: 1000 random vectors with random out_ready -> the emitted index sequence per vector equals the ascending set-bit list, and the scoreboard sees no loss or duplication.
